jts16_nvram_dump: RTL and testbench

// - Reader side of the game's NVRAM/EEPROM dump path: walks the byte address bus into the game core,

---
 rtl/jts16_dump_pkg.sv | 18 +
 rtl/jts16_nvram_dump.sv | 213 +++++++++++++++++++++
 tb/tb_jts16_nvram_dump.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jts16_dump_pkg.sv
// Shared types and constants for the NVRAM/EEPROM dump reader.
// Contents: FSM state enum, checksum width, latency counter width.
package jts16_dump_pkg;

    localparam int unsigned CKSUM_W = 16;
    // Read latency is at most 15 cycles, so a 4-bit counter covers it.
    localparam int unsigned LAT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        SEND,
        TRAILER,
        DONE
    } state_t;

endpackage

// File: rtl/jts16_nvram_dump.sv
// jts16_nvram_dump: reader side of the game NVRAM/EEPROM dump path.
// Walks ioctl_addr from 0 to DUMP_LEN-1, waits RD_LAT cycles per address for the
// game to return ioctl_din, and streams each byte to the HPS with valid/ready.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle pulse, begins a dump when idle
//   abort              level, cancels a dump in progress
//   ioctl_addr [AW]    byte address presented to the game
//   ioctl_ram          high while a dump is in progress
//   ioctl_din  [8]     byte returned by the game
//   up_data/up_valid   byte stream to HPS, held stable until up_ready
//   up_ready           HPS accept
//   busy               high from start acceptance until completion
//   done               one-cycle pulse after the last byte is accepted
//
// Build option: define JTS16_DUMP_CKSUM_EN to append a 16-bit additive checksum
// of all data bytes (high byte, then low byte) after the last data byte.
module jts16_nvram_dump
    import jts16_dump_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DUMP_LEN = 32'h4000,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] ioctl_addr,
    output logic          ioctl_ram,
    input  logic [7:0]    ioctl_din,
    output logic [7:0]    up_data,
    output logic          up_valid,
    input  logic          up_ready,
    output logic          busy,
    output logic          done
);

    // Final address; for DUMP_LEN == 2**AW this is all ones, so the counter never wraps.
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DUMP_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               ram_q, ram_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               hshake;

`ifdef JTS16_DUMP_CKSUM_EN
    logic [CKSUM_W-1:0] cksum_q, cksum_d;
    logic [CKSUM_W-1:0] cksum_sum;
    logic               trl_q, trl_d;
`endif

    assign hshake = valid_q & up_ready;

`ifdef JTS16_DUMP_CKSUM_EN
    // Running sum including the byte being accepted this cycle.
    assign cksum_sum = cksum_q + CKSUM_W'(data_q);
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ram_d   = ram_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lat_d   = lat_q;
`ifdef JTS16_DUMP_CKSUM_EN
        cksum_d = cksum_q;
        trl_d   = trl_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    addr_d  = '0;
                    ram_d   = 1'b1;
                    busy_d  = 1'b1;
                    lat_d   = '0;
`ifdef JTS16_DUMP_CKSUM_EN
                    cksum_d = '0;
`endif
                    state_d = SETUP;
                end
            end

            SETUP: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = ioctl_din;
                    valid_d = 1'b1;
                    state_d = SEND;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            SEND: begin
                if (hshake) begin
                    valid_d = 1'b0;
`ifdef JTS16_DUMP_CKSUM_EN
                    cksum_d = cksum_sum;
`endif
                    if (addr_q == LAST_ADDR) begin
`ifdef JTS16_DUMP_CKSUM_EN
                        data_d  = cksum_sum[15:8];
                        valid_d = 1'b1;
                        trl_d   = 1'b0;
                        state_d = TRAILER;
`else
                        busy_d  = 1'b0;
                        ram_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
`endif
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        lat_d   = '0;
                        state_d = SETUP;
                    end
                end
            end

`ifdef JTS16_DUMP_CKSUM_EN
            // Two checksum bytes back to back: high byte first, then low byte.
            TRAILER: begin
                if (hshake) begin
                    if (!trl_q) begin
                        data_d = cksum_q[7:0];
                        trl_d  = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        ram_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            addr_d  = '0;
            ram_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            lat_d   = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ram_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lat_q   <= '0;
`ifdef JTS16_DUMP_CKSUM_EN
            cksum_q <= '0;
            trl_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ram_q   <= ram_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lat_q   <= lat_d;
`ifdef JTS16_DUMP_CKSUM_EN
            cksum_q <= cksum_d;
            trl_q   <= trl_d;
`endif
        end
    end

    assign ioctl_addr = addr_q;
    assign ioctl_ram  = ram_q;
    assign up_data    = data_q;
    assign up_valid   = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_jts16_nvram_dump.sv
// Self-checking bench for jts16_nvram_dump (DUMP_LEN=4, RD_LAT=2).
// The game is modelled as a RD_LAT-deep pipeline returning addr ^ 8'hA5.
// Honours JTS16_DUMP_CKSUM_EN when building the expected byte stream.
module tb_jts16_nvram_dump;

    localparam int unsigned AW  = 16;
    localparam int unsigned LEN = 4;
    localparam int unsigned LAT = 2;
    localparam int          BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          up_ready = 1'b0;
    logic [AW-1:0] ioctl_addr;
    logic          ioctl_ram;
    logic [7:0]    ioctl_din;
    logic [7:0]    up_data;
    logic          up_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         acc_cyc[$];
    int         ndone;
    bit         tmo;

    jts16_nvram_dump #(
        .AW       (AW),
        .DUMP_LEN (LEN),
        .RD_LAT   (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .ioctl_addr (ioctl_addr),
        .ioctl_ram  (ioctl_ram),
        .ioctl_din  (ioctl_din),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Game read path: the byte for an address is visible LAT clocks after it changes.
    logic [AW-1:0] pipe0 = '0;
    logic [AW-1:0] pipe1 = '0;
    always @(posedge clk) begin
        pipe0 <= ioctl_addr;
        pipe1 <= pipe0;
    end
    assign ioctl_din = pipe1[7:0] ^ 8'hA5;

    // Expected upload: each address xor A5, then the checksum trailer when enabled.
    task automatic build_expected();
        logic [15:0] sum;
        logic [7:0]  b;
        exp_q.delete();
        sum = 16'h0;
        for (int a = 0; a < int'(LEN); a++) begin
            b = 8'(a) ^ 8'hA5;
            exp_q.push_back(b);
            sum = sum + 16'(b);
        end
`ifdef JTS16_DUMP_CKSUM_EN
        exp_q.push_back(sum[15:8]);
        exp_q.push_back(sum[7:0]);
`endif
    endtask

    // Start a dump and collect accepted bytes until done (or the cycle budget runs out).
    task automatic run_dump(input int pct, input bit restart_in_send);
        int cyc;
        bit restarted;
        got.delete();
        acc_cyc.delete();
        ndone = 0;
        tmo = 1'b0;
        restarted = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < BUDGET && done !== 1'b1) begin
            up_ready = ($urandom_range(0, 99) < pct);
            if (restart_in_send && !restarted && up_valid === 1'b1) begin
                start = 1'b1;
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (up_valid === 1'b1 && up_ready === 1'b1) begin
                got.push_back(up_data);
                acc_cyc.push_back(cyc);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        up_ready = 1'b0;
        if (cyc >= BUDGET) tmo = 1'b1;
        if (done === 1'b1) ndone++;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ioctl_addr !== '0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", ioctl_addr); end
        checks++; if (ioctl_ram !== 1'b0) begin failures++; $display("FAIL reset_ram: got %b expected 0", ioctl_ram); end
        checks++; if (up_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %0h expected 0", up_data); end
        checks++; if (up_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", up_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_abort_busy: got %b expected 0", busy); end
        checks++; if (ioctl_ram !== 1'b0) begin failures++; $display("FAIL idle_abort_ram: got %b expected 0", ioctl_ram); end
        repeat (4) @(negedge clk);
        checks++; if (up_valid !== 1'b0) begin failures++; $display("FAIL idle_abort_valid: got %b expected 0", up_valid); end
    endtask

    task automatic test_basic();
        run_dump(100, 1'b0);
        checks++; if (tmo) begin failures++; $display("FAIL basic_timeout: got timeout expected done"); end
        checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL basic_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL basic_byte%0d: got %0h expected %0h", i, got[i], exp_q[i]); end
        end
        if (acc_cyc.size() >= int'(LEN)) begin
            checks++; if (acc_cyc[0] != int'(LAT) + 2) begin failures++; $display("FAIL basic_first_latency: got %0d expected %0d", acc_cyc[0], LAT + 2); end
            for (int i = 1; i < int'(LEN); i++) begin
                checks++; if (acc_cyc[i] - acc_cyc[i-1] != int'(LAT) + 2) begin failures++; $display("FAIL basic_spacing%0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], LAT + 2); end
            end
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d expected 1", ndone); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        checks++; if (ioctl_ram !== 1'b0) begin failures++; $display("FAIL basic_ram_after: got %b expected 0", ioctl_ram); end
        checks++; if (ioctl_addr !== AW'(LEN - 1)) begin failures++; $display("FAIL basic_addr_kept: got %0h expected %0h", ioctl_addr, LEN - 1); end
    endtask

    task automatic test_backpressure();
        int cyc;
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        up_ready = 1'b1;
        while (cyc < BUDGET && !(up_valid === 1'b1 && ioctl_addr === AW'(1))) begin
            if (up_valid === 1'b1) got.push_back(up_data);
            @(negedge clk);
            cyc++;
        end
        up_ready = 1'b0;
        checks++; if (cyc >= BUDGET) begin failures++; $display("FAIL bp_reach_byte1: got timeout expected byte 1 valid"); end
        repeat (5) begin
            @(negedge clk);
            checks++; if (up_valid !== 1'b1 || up_data !== 8'hA4 || ioctl_addr !== AW'(1)) begin
                failures++;
                $display("FAIL bp_hold: got valid=%b data=%0h addr=%0h expected valid=1 data=a4 addr=1", up_valid, up_data, ioctl_addr);
            end
        end
        cyc = 0;
        up_ready = 1'b1;
        while (cyc < BUDGET && done !== 1'b1) begin
            if (up_valid === 1'b1) got.push_back(up_data);
            @(negedge clk);
            cyc++;
        end
        up_ready = 1'b0;
        checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d: got %0h expected %0h", i, got[i], exp_q[i]); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int cyc;
        int extra_done;
        int extra_valid;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        up_ready = 1'b1;
        cyc = 0;
        while (cyc < BUDGET && ioctl_addr !== AW'(2)) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= BUDGET) begin failures++; $display("FAIL abort_reach_addr2: got timeout expected addr 2"); end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (up_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b expected 0", up_valid); end
        checks++; if (ioctl_ram !== 1'b0) begin failures++; $display("FAIL abort_ram: got %b expected 0", ioctl_ram); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (ioctl_addr !== '0) begin failures++; $display("FAIL abort_addr: got %0h expected 0", ioctl_addr); end
        extra_done = 0;
        extra_valid = 0;
        repeat (10) begin
            if (done === 1'b1) extra_done++;
            if (up_valid === 1'b1) extra_valid++;
            @(negedge clk);
        end
        up_ready = 1'b0;
        checks++; if (extra_done != 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", extra_done); end
        checks++; if (extra_valid != 0) begin failures++; $display("FAIL abort_no_valid: got %0d expected 0", extra_valid); end
    endtask

    task automatic test_restart_ignored();
        run_dump(70, 1'b1);
        checks++; if (tmo) begin failures++; $display("FAIL restart_timeout: got timeout expected done"); end
        checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL restart_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL restart_byte%0d: got %0h expected %0h", i, got[i], exp_q[i]); end
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL restart_done_pulses: got %0d expected 1", ndone); end
    endtask

    task automatic test_random();
        int pct;
        for (int r = 0; r < 4; r++) begin
            pct = int'($urandom_range(20, 90));
            run_dump(pct, 1'b0);
            checks++; if (tmo || got.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count: got %0d expected %0d", r, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_byte%0d: got %0h expected %0h", r, i, got[i], exp_q[i]); end
            end
            checks++; if (ndone != 1) begin failures++; $display("FAIL rand%0d_done_pulses: got %0d expected 1", r, ndone); end
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        up_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (ioctl_ram !== 1'b1) begin failures++; $display("FAIL areset_pre_ram: got %b expected 1", ioctl_ram); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ioctl_addr !== '0 || ioctl_ram !== 1'b0 || up_data !== 8'h00 || up_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL areset_outputs: got addr=%0h ram=%b data=%0h valid=%b busy=%b done=%b expected all 0",
                     ioctl_addr, ioctl_ram, up_data, up_valid, busy, done);
        end
        up_ready = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_no_done: got %b expected 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        run_dump(100, 1'b0);
        checks++; if (tmo || got.size() != exp_q.size()) begin failures++; $display("FAIL areset_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL areset_byte%0d: got %0h expected %0h", i, got[i], exp_q[i]); end
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL areset_done_pulses: got %0d expected 1", ndone); end
    endtask

    initial begin
        build_expected();
        test_reset();
        test_start_abort_idle();
        test_basic();
        test_backpressure();
        test_abort();
        test_restart_ignored();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
